// File: rtl/io_bel_multi_reg_if.sv
// Fabric and pad signal bundle for the N-channel bidirectional IO BEL.
// The master side drives fabric data, pad input and config. The slave side is the BEL.
interface io_bel_multi_reg_if #(
  parameter int NCH   = 2,
  parameter int CFG_W = 5
);
  logic [NCH-1:0]       I;
  logic [NCH-1:0]       T;
  logic [NCH-1:0]       O;
  logic [NCH-1:0]       Q;
  logic [NCH-1:0]       Edge;
  logic [NCH-1:0]       O_top;
  logic [NCH-1:0]       I_top;
  logic [NCH-1:0]       T_top;
  logic [NCH*CFG_W-1:0] ConfigBits;

  modport master (
    output I, T, O_top, ConfigBits,
    input  O, Q, Edge, I_top, T_top
  );

  modport slave (
    input  I, T, O_top, ConfigBits,
    output O, Q, Edge, I_top, T_top
  );
endinterface

// File: rtl/io_bel_multi_reg.sv
// N-channel bidirectional IO BEL with configurable input capture (direct/registered/sync/filtered),
// optional registered output and tristate paths, invert options and a per-channel edge pulse.
module io_bel_multi_reg #(
  parameter int NCH      = 2,
  parameter int FILT_LEN = 4,
  parameter int CFG_W    = 5
) (
  input logic                UserCLK,
  input logic                reset,
  io_bel_multi_reg_if.slave  io
);

  localparam int                CNT_W   = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILT_LEN - 1);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CFG_W-1:0] cfg;
      logic [1:0]       in_mode;
      logic             out_reg;
      logic             t_inv;
      logic             in_inv;

      logic x;
      logic tt;
      logic o_c;

      logic r1_q, r1_d;
      logic s1_q, s1_d;
      logic s2_q, s2_d;
      logic f_q, f_d;
      logic q_q, q_d;
      logic qp_q, qp_d;
      logic itop_q, itop_d;
      logic ttop_q, ttop_d;
      logic [CNT_W-1:0] c_q, c_d;

      assign cfg     = io.ConfigBits[gi*CFG_W +: CFG_W];
      assign in_mode = cfg[1:0];
      assign out_reg = cfg[2];
      assign t_inv   = cfg[3];
      assign in_inv  = cfg[4];

      assign x  = io.O_top[gi] ^ in_inv;
      assign tt = io.T[gi] ^ t_inv;

      // Every input-path stage runs regardless of in_mode, so switching modes only re-steers the mux.
      always_comb begin
        r1_d   = x;
        s1_d   = x;
        s2_d   = s1_q;
        f_d    = f_q;
        c_d    = c_q;
        if (s2_q == f_q) begin
          c_d = '0;
        end else if (c_q == CNT_MAX) begin
          f_d = s2_q;
          c_d = '0;
        end else begin
          c_d = c_q + 1'b1;
        end

        case (in_mode)
          2'b00:   o_c = x;
          2'b01:   o_c = r1_q;
          2'b10:   o_c = s2_q;
          default: o_c = f_q;
        endcase

        q_d    = o_c;
        qp_d   = q_q;
        itop_d = io.I[gi];
        ttop_d = tt;
      end

      always_ff @(posedge UserCLK) begin
        if (reset) begin
          r1_q   <= 1'b0;
          s1_q   <= 1'b0;
          s2_q   <= 1'b0;
          f_q    <= 1'b0;
          c_q    <= '0;
          q_q    <= 1'b0;
          qp_q   <= 1'b0;
          itop_q <= 1'b0;
          ttop_q <= 1'b1;
        end else begin
          r1_q   <= r1_d;
          s1_q   <= s1_d;
          s2_q   <= s2_d;
          f_q    <= f_d;
          c_q    <= c_d;
          q_q    <= q_d;
          qp_q   <= qp_d;
          itop_q <= itop_d;
          ttop_q <= ttop_d;
        end
      end

      assign io.O[gi]     = o_c;
      assign io.Q[gi]     = q_q;
      assign io.Edge[gi]  = q_q ^ qp_q;
      assign io.I_top[gi] = out_reg ? itop_q : io.I[gi];
      assign io.T_top[gi] = out_reg ? ttop_q : tt;
    end
  endgenerate

endmodule
